cmd_sched: RTL and testbench

Command scheduler between the UART wrapper and the command processor. Buffers up to DEPTH 16-bit route commands from the UART, acknowledges each one exactly once, and presents them in order to the command processor over the existing cmd/cmd_rdy/clr_cmd_rdy handshake. Also provides a flush path that aborts the route, for example on a bumper hit, and a stall watchdog that flags a head command left unconsumed too long.

---
 rtl/cmd_sched_pkg.sv | 13 +
 rtl/cmd_fifo.sv | 73 +++++++
 rtl/cmd_sched.sv | 103 ++++++++++
 tb/tb_cmd_sched.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_sched_pkg.sv
// Shared constants and types for the command scheduler.
package cmd_sched_pkg;

  localparam int unsigned CMD_W    = 16;
  localparam int unsigned TMO_FAST = 17;
  localparam int unsigned TMO_SLOW = 26;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_WAIT = 1'b1
  } rx_state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Command storage ring: pointers, occupancy and full/empty flags. Storage is not reset.
module cmd_fifo import cmd_sched_pkg::*; #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [CMD_W-1:0] wdata_i,
  output logic [CMD_W-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  cnt_o
);

  localparam logic [PtrW-1:0] PtrOne  = 1;
  localparam logic [CntW-1:0] CntOne  = 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CntFull);
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a push into a full ring is still legal.
  assign do_pop  = pop_i && !flush_i && !empty_o;
  assign do_push = push_i && !flush_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CntOne;
        2'b01:   cnt_d = cnt_q - CntOne;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/cmd_sched.sv
// Command scheduler: UART ingest FSM, command queue, head-of-queue output and stall watchdog.
module cmd_sched import cmd_sched_pkg::*; #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned FAST_SIM = 0,
  parameter int unsigned TMO_W    = (FAST_SIM != 0) ? TMO_FAST : TMO_SLOW,
  localparam int unsigned CntW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CMD_W-1:0] rx_cmd_i,
  input  logic             rx_rdy_i,
  output logic             rx_clr_o,
  output logic [CMD_W-1:0] cmd_o,
  output logic             cmd_rdy_o,
  input  logic             clr_cmd_rdy_i,
  input  logic             flush_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  cnt_o,
  output logic             stall_o
);

  localparam logic [TMO_W-1:0] TmoOne = 1;

  rx_state_t        state_q, state_d;
  logic             push, pop, rx_clr;
  logic             full, empty;
  logic [CMD_W-1:0] head;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush_i),
    .wdata_i (rx_cmd_i),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .cnt_o   (cnt_o)
  );

  assign pop = clr_cmd_rdy_i && !empty;

  // RX_WAIT holds until the wrapper drops rx_rdy so one word is never captured twice.
  // A flush in RX_WAIT does not re-acknowledge: that word was already acked.
  always_comb begin
    state_d = state_q;
    rx_clr  = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (flush_i) begin
          if (rx_rdy_i) begin
            rx_clr  = 1'b1;
            state_d = RX_WAIT;
          end
        end else if (rx_rdy_i && !full) begin
          push    = 1'b1;
          rx_clr  = 1'b1;
          state_d = RX_WAIT;
        end
      end
      RX_WAIT: begin
        if (!rx_rdy_i) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RX_IDLE;
    else     state_q <= state_d;
  end

  // Mealy ack is held off while reset is asserted.
  assign rx_clr_o = rx_clr && !rst;

  // Watchdog: counts head-waiting cycles, saturates at all-ones which is the stall flag.
  always_comb begin
    tmo_d = tmo_q;
    if (flush_i || empty || clr_cmd_rdy_i) begin
      tmo_d = '0;
    end else if (tmo_q != '1) begin
      tmo_d = tmo_q + TmoOne;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end

  assign stall_o   = (tmo_q == '1);
  assign cmd_o     = empty ? '0 : head;
  assign cmd_rdy_o = !empty;
  assign full_o    = full;
  assign empty_o   = empty;

endmodule

// File: tb/tb_cmd_sched.sv
// Randomized and directed bench for cmd_sched with a queue-based reference model and pop scoreboard.
module tb_cmd_sched;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TMO_W   = 10;
  localparam int          TMO_MAX = (1 << TMO_W) - 1;
  localparam int unsigned CntW    = $clog2(DEPTH) + 1;

  logic            clk, rst;
  logic [15:0]     rx_cmd;
  logic            rx_rdy, rx_clr;
  logic [15:0]     cmd;
  logic            cmd_rdy, clr_cmd_rdy, flush;
  logic            full, empty, stall;
  logic [CntW-1:0] cnt;

  cmd_sched #(
    .DEPTH    (DEPTH),
    .FAST_SIM (1),
    .TMO_W    (TMO_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_cmd_i      (rx_cmd),
    .rx_rdy_i      (rx_rdy),
    .rx_clr_o      (rx_clr),
    .cmd_o         (cmd),
    .cmd_rdy_o     (cmd_rdy),
    .clr_cmd_rdy_i (clr_cmd_rdy),
    .flush_i       (flush),
    .full_o        (full),
    .empty_o       (empty),
    .cnt_o         (cnt),
    .stall_o       (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the queue contents are the words accepted and not yet consumed.
  logic [15:0] exp_q[$];
  int          m_cnt   = 0;
  bit          m_wait  = 1'b0;
  int          m_tmo   = 0;
  int          ack_cnt = 0;

  always @(negedge clk) begin
    bit e_clr, acc, popd;
    if (rst) begin
      m_cnt = 0; m_wait = 1'b0; m_tmo = 0;
      exp_q.delete();
      chk("rst_rx_clr", 32'(rx_clr), 0);
      chk("rst_cnt", 32'(cnt), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_cmd", 32'(cmd), 0);
      chk("rst_stall", 32'(stall), 0);
    end else begin
      e_clr = rx_rdy && !m_wait && (flush || m_cnt < int'(DEPTH));
      chk("rx_clr", 32'(rx_clr), 32'(e_clr));
      chk("cnt", 32'(cnt), 32'(m_cnt));
      chk("cmd_rdy", 32'(cmd_rdy), 32'(m_cnt != 0));
      chk("empty", 32'(empty), 32'(m_cnt == 0));
      chk("full", 32'(full), 32'(m_cnt == int'(DEPTH)));
      chk("stall", 32'(stall), 32'(m_tmo == TMO_MAX));
      if (m_cnt == 0) chk("cmd_empty", 32'(cmd), 0);
      if (e_clr) ack_cnt++;
      popd = clr_cmd_rdy && m_cnt != 0;
      acc  = e_clr && !flush;
      if (flush) begin
        m_cnt  = 0;
        m_tmo  = 0;
        m_wait = rx_rdy;
        exp_q.delete();
      end else begin
        if (acc) exp_q.push_back(rx_cmd);
        if (m_cnt == 0 || clr_cmd_rdy) m_tmo = 0;
        else if (m_tmo < TMO_MAX)      m_tmo = m_tmo + 1;
        m_cnt  = m_cnt + int'(acc) - int'(popd);
        m_wait = m_wait ? rx_rdy : acc;
      end
    end
  end

  // Scoreboard monitor: every consumed head must be the oldest accepted word.
  always @(negedge clk) begin
    if (!rst && clr_cmd_rdy && !flush && cmd_rdy) begin
      if (exp_q.size() == 0) chk("pop_unexpected", 32'(cmd_rdy), 0);
      else                   chk("pop_order", 32'(cmd), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int a0, input string name);
    int n = 0;
    while (ack_cnt == a0 && n < 100) begin
      tick();
      n++;
    end
    if (ack_cnt == a0) chk(name, 32'(ack_cnt - a0), 1);
  endtask

  task automatic send_word(input logic [15:0] w);
    int a0 = ack_cnt;
    rx_cmd = w;
    rx_rdy = 1'b1;
    wait_ack(a0, "ack_timeout");
    repeat ($urandom_range(0, 2)) tick();
    rx_rdy = 1'b0;
    tick();
  endtask

  task automatic pop_one();
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    clr_cmd_rdy = 1'b1;
    while (cnt != '0 && n < 50) begin
      tick();
      n++;
    end
    clr_cmd_rdy = 1'b0;
    chk("drain_empty", 32'(empty), 1);
  endtask

  initial begin
    int a0, n;
    rst = 1'b1; rx_cmd = '0; rx_rdy = 1'b0; clr_cmd_rdy = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Basic ordering
    for (int i = 1; i <= 3; i++) send_word(16'(i));
    chk("basic_cnt3", 32'(cnt), 3);
    for (int i = 0; i < 3; i++) pop_one();
    chk("basic_empty", 32'(empty), 1);

    // Backpressure: fifth word waits until a slot frees
    for (int i = 0; i < 4; i++) send_word(16'hA0 + 16'(i));
    chk("bp_full", 32'(full), 1);
    rx_cmd = 16'hBEEF; rx_rdy = 1'b1; a0 = ack_cnt;
    repeat (5) tick();
    chk("bp_no_ack", 32'(ack_cnt - a0), 0);
    pop_one();
    wait_ack(a0, "bp_ack_timeout");
    chk("bp_one_ack", 32'(ack_cnt - a0), 1);
    rx_rdy = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) pop_one();
    chk("bp_last", 32'(cmd), 32'h0000BEEF);
    pop_one();

    // Push and pop in the same cycle; pointers wrap repeatedly
    for (int i = 0; i < 3; i++) send_word(16'h100 + 16'(i));
    for (int i = 0; i < 8; i++) begin
      rx_cmd = 16'h200 + 16'(i); rx_rdy = 1'b1; clr_cmd_rdy = 1'b1;
      tick();
      clr_cmd_rdy = 1'b0; rx_rdy = 1'b0;
      tick();
      chk("pp_cnt", 32'(cnt), 3);
    end
    drain();

    // Flush with a pending UART word and a pop in the same cycle
    for (int i = 0; i < 3; i++) send_word(16'h300 + 16'(i));
    rx_cmd = 16'hDEAD; rx_rdy = 1'b1; flush = 1'b1; clr_cmd_rdy = 1'b1; a0 = ack_cnt;
    tick();
    flush = 1'b0; clr_cmd_rdy = 1'b0;
    chk("fl_ack", 32'(ack_cnt - a0), 1);
    chk("fl_cnt", 32'(cnt), 0);
    chk("fl_cmd", 32'(cmd), 0);
    chk("fl_cmd_rdy", 32'(cmd_rdy), 0);
    tick();
    rx_rdy = 1'b0;
    tick();
    send_word(16'h5A5A);
    chk("fl_only_cnt", 32'(cnt), 1);
    chk("fl_only_cmd", 32'(cmd), 32'h00005A5A);
    pop_one();

    // Watchdog timing
    rx_cmd = 16'h7777; rx_rdy = 1'b1; n = 0;
    while (!cmd_rdy && n < 20) begin tick(); n++; end
    rx_rdy = 1'b0;
    n = 0;
    while (!stall && n < 2 * TMO_MAX) begin tick(); n++; end
    chk("wd_period", 32'(n), 32'(TMO_MAX));
    pop_one();
    chk("wd_clear", 32'(stall), 0);

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      if (rx_rdy && ack_cnt != a0 && $urandom_range(0, 1) == 0) begin
        rx_rdy = 1'b0;
      end else if (!rx_rdy && $urandom_range(0, 2) == 0) begin
        rx_cmd = 16'($urandom); rx_rdy = 1'b1; a0 = ack_cnt;
      end
      clr_cmd_rdy = (c % 400 < 200) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 0);
      flush = ($urandom_range(0, 79) == 0);
      tick();
    end
    flush = 1'b0; clr_cmd_rdy = 1'b0; rx_rdy = 1'b0;
    tick();
    drain();

    // Asynchronous reset in RX_WAIT with two queued
    send_word(16'h0A01);
    rx_cmd = 16'h0A02; rx_rdy = 1'b1; a0 = ack_cnt;
    wait_ack(a0, "rst_pre_ack");
    tick();
    chk("pre_rst_cnt", 32'(cnt), 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_cnt", 32'(cnt), 0);
    chk("arst_cmd_rdy", 32'(cmd_rdy), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_rx_clr", 32'(rx_clr), 0);
    tick();
    #2 rst = 1'b0;
    a0 = ack_cnt;
    wait_ack(a0, "post_rst_ack");
    chk("post_rst_one_ack", 32'(ack_cnt - a0), 1);
    rx_rdy = 1'b0;
    tick();
    chk("post_rst_cmd", 32'(cmd), 32'h00000A02);
    pop_one();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
